// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like request path: source tags, the fixed
// instruction transfer size and a packed request bundle. The AXI bridge uses
// this package as well.
package sram_like_arbiter_pkg;

    // Tag stored per outstanding request; selects the response port.
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Request fields carried from a CPU port to the memory side.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_tag_fifo.sv
// One-bit-wide tag FIFO holding the source of each accepted, unanswered
// request. Responses return in request order, so the head tag always names
// the port owed the next response.
module sram_like_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] tag_mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = tag_mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of 2.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; an entry is only read after it was written.
        if (do_push) tag_mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the CPU instruction and data sram-like ports onto one memory-side
// sram-like port. Data has priority unless a stalled request holds the grant
// lock; responses are steered back by the tag FIFO. Request and response
// paths are combinational; only the lock and the FIFO are registered.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic      lock_q, lock_d;
    logic      lock_src_q, lock_src_d;
    logic      stray_err_q;
    logic      grant;
    logic      sel_req;
    logic      req_int;
    logic      accept;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_head;
    logic      rsp_pop;
    logic      stray_rsp;
    sram_req_t inst_bundle;
    sram_req_t data_bundle;
    sram_req_t sel_bundle;

    assign inst_bundle = '{wr: 1'b0, size: SIZE_WORD, addr: inst_addr, wdata: 32'h0};
    assign data_bundle = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    // Grant selection: a stalled request keeps its port, otherwise data wins.
    always_comb begin
        grant      = lock_q ? lock_src_q : (data_req ? SRC_DATA : SRC_INST);
        sel_req    = (grant == SRC_DATA) ? data_req : inst_req;
        sel_bundle = (grant == SRC_DATA) ? data_bundle : inst_bundle;
    end

    assign req_int   = sel_req & ~fifo_full;
    assign accept    = req_int & mem_addr_ok;
    assign rsp_pop   = mem_data_ok & ~fifo_empty;
    assign stray_rsp = mem_data_ok & fifo_empty;

    // Lock next-state: set on a stalled request, release on acceptance.
    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (req_int && !mem_addr_ok) begin
            lock_d     = 1'b1;
            lock_src_d = grant;
        end
    end

    // Lock and protocol-violation flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q      <= 1'b0;
            lock_src_q  <= SRC_INST;
            stray_err_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
            stray_err_q <= stray_err_q | stray_rsp;
        end
    end

    sram_like_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (grant),
        .pop    (rsp_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    // Output drive; everything is forced low while reset is asserted.
    always_comb begin
        mem_req      = resetn & req_int;
        mem_wr       = resetn & sel_bundle.wr;
        mem_size     = resetn ? sel_bundle.size  : 2'd0;
        mem_addr     = resetn ? sel_bundle.addr  : 32'h0;
        mem_wdata    = resetn ? sel_bundle.wdata : 32'h0;
        inst_addr_ok = resetn & accept & (grant == SRC_INST);
        data_addr_ok = resetn & accept & (grant == SRC_DATA);
        inst_data_ok = resetn & rsp_pop & (fifo_head == SRC_INST);
        data_data_ok = resetn & rsp_pop & (fifo_head == SRC_DATA);
        inst_rdata   = resetn ? mem_rdata : 32'h0;
        data_rdata   = resetn ? mem_rdata : 32'h0;
    end

endmodule
